// File: rtl/w_load_align_unit.sv
// Load alignment unit: issues one or two aligned word reads, merges, shifts and extends to XLEN (MISALIGN_TRAP_EN traps crossing loads).
// Latency: 4 cycles aligned, 6 crossing, 2 illegal (accept to o_con_valid); memory stall adds cycles.
// Backpressure: o_con_ready only in IDLE; upstream holds its request until accepted.
module w_load_align_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_con_valid,
    output logic            o_con_ready,
    input  logic [XLEN-1:0] i_data_addr,
    input  logic [2:0]      i_con_loadsig,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_con_valid,
    output logic [XLEN-1:0] o_data_Wdata,
    output logic            o_con_err
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam logic [OFFW+3:0] NBW = (OFFW + 4)'(NB);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD0  = 3'd1;
    localparam logic [2:0] S_WT0  = 3'd2;
    localparam logic [2:0] S_RD1  = 3'd3;
    localparam logic [2:0] S_WT1  = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0]      state;
    logic [XLEN-1:0] addr_q;
    logic [2:0]      sig_q;
    logic            cross_q;
    logic [XLEN-1:0] beat0_q;
    logic [XLEN-1:0] data_q;
    logic            err_q;

    logic [3:0]      in_size;
    logic            in_legal;
    logic [OFFW+3:0] in_end;
    logic            in_cross;
    logic [XLEN-1:0] aligned;

    // Size of zero marks a code that is illegal for this XLEN.
    function automatic logic [3:0] size_of(input logic [2:0] sig);
        case (sig)
            3'b000, 3'b100: size_of = 4'd1;
            3'b001, 3'b101: size_of = 4'd2;
            3'b010:         size_of = 4'd4;
            3'b110:         size_of = (XLEN == 64) ? 4'd4 : 4'd0;
            3'b011:         size_of = (XLEN == 64) ? 4'd8 : 4'd0;
            default:        size_of = 4'd0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] merged,
                                                input logic [OFFW-1:0]   off,
                                                input logic [2:0]        sig);
        logic [2*XLEN-1:0] shifted;
        logic [XLEN-1:0]   sh;
        logic [XLEN-1:0]   res;
        logic [3:0]        sz;
        logic              top;
        shifted = merged >> {off, 3'b000};
        sh      = shifted[XLEN-1:0];
        sz      = size_of(sig);
        case (sz)
            4'd1:    top = sh[7];
            4'd2:    top = sh[15];
            4'd4:    top = sh[31];
            default: top = 1'b0;
        endcase
        res = '0;
        for (int b = 0; b < NB; b++) begin
            res[b*8 +: 8] = (b < int'(sz)) ? sh[b*8 +: 8] : {8{top & ~sig[2]}};
        end
        return res;
    endfunction

    always_comb begin
        in_size  = size_of(i_con_loadsig);
        in_legal = (in_size != 4'd0);
        in_end   = {4'b0000, i_data_addr[OFFW-1:0]} + {{OFFW{1'b0}}, in_size};
        in_cross = (in_end > NBW);
    end

    assign aligned      = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign o_con_ready  = (state == S_IDLE);
    assign o_mem_req    = (state == S_RD0) || (state == S_RD1);
    assign o_mem_addr   = (state == S_RD0) ? aligned :
                          (state == S_RD1) ? aligned + XLEN'(NB) : '0;
    assign o_con_valid  = (state == S_RESP);
    assign o_data_Wdata = data_q;
    assign o_con_err    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            sig_q   <= 3'b000;
            cross_q <= 1'b0;
            beat0_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_con_valid) begin
                        addr_q  <= i_data_addr;
                        sig_q   <= i_con_loadsig;
                        cross_q <= in_cross;
                        if (!in_legal) begin
                            state  <= S_RESP;
                            data_q <= '0;
                            err_q  <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                        end else if (in_cross) begin
                            state  <= S_RESP;
                            data_q <= '0;
                            err_q  <= 1'b1;
`endif
                        end else begin
                            state <= S_RD0;
                        end
                    end
                end
                S_RD0: state <= S_WT0;
                S_WT0: begin
                    if (i_mem_rvalid) begin
                        beat0_q <= i_mem_rdata;
                        if (cross_q) begin
                            state <= S_RD1;
                        end else begin
                            state  <= S_RESP;
                            data_q <= extract({{XLEN{1'b0}}, i_mem_rdata}, addr_q[OFFW-1:0], sig_q);
                            err_q  <= 1'b0;
                        end
                    end
                end
                S_RD1: state <= S_WT1;
                S_WT1: begin
                    if (i_mem_rvalid) begin
                        state  <= S_RESP;
                        data_q <= extract({i_mem_rdata, beat0_q}, addr_q[OFFW-1:0], sig_q);
                        err_q  <= 1'b0;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_w_load_align_unit.sv
// Bench for w_load_align_unit at XLEN=32 and XLEN=64 against a byte-addressed memory reference model.
module tb_w_load_align_unit;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v32, rdy32, req32, rv32, ov32, err32;
    logic        resp32 = 1'b0, inj32 = 1'b0;
    logic [2:0]  s32;
    logic [31:0] a32, ma32, rd32, wd32;
    logic        v64, rdy64, req64, rv64, ov64, err64;
    logic        resp64 = 1'b0;
    logic [2:0]  s64;
    logic [63:0] a64, ma64, rd64, wd64;

    assign rv32 = resp32 | inj32;
    assign rv64 = resp64;

    w_load_align_unit #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .i_con_valid(v32), .o_con_ready(rdy32),
        .i_data_addr(a32), .i_con_loadsig(s32), .o_mem_req(req32), .o_mem_addr(ma32),
        .i_mem_rvalid(rv32), .i_mem_rdata(rd32), .o_con_valid(ov32),
        .o_data_Wdata(wd32), .o_con_err(err32));

    w_load_align_unit #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .i_con_valid(v64), .o_con_ready(rdy64),
        .i_data_addr(a64), .i_con_loadsig(s64), .o_mem_req(req64), .o_mem_addr(ma64),
        .i_mem_rvalid(rv64), .i_mem_rdata(rd64), .o_con_valid(ov64),
        .o_data_Wdata(wd64), .o_con_err(err64));

    int tests = 0;
    int fails = 0;
    int lat = 1;
    logic [7:0]  mem8 [logic [63:0]];
    logic [63:0] q32 [$];
    logic [63:0] q64 [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] amask(input bit w64, input logic [63:0] a);
        return w64 ? a : (a & 64'h0000_0000_FFFF_FFFF);
    endfunction

    function automatic logic [7:0] byte_at(input logic [63:0] a);
        return mem8.exists(a) ? mem8[a] : (a[7:0] ^ 8'h5A);
    endfunction

    function automatic logic [63:0] rd_word(input bit w64, input logic [63:0] a);
        logic [63:0] w = '0;
        for (int i = 0; i < (w64 ? 8 : 4); i++)
            w |= {56'd0, byte_at(amask(w64, a + 64'(i)))} << (8 * i);
        return w;
    endfunction

    task automatic put_word(input logic [63:0] a, input logic [63:0] d, input int nb);
        for (int i = 0; i < nb; i++) mem8[a + 64'(i)] = d[8*i +: 8];
    endtask

    // Reference: gather size bytes little-endian from memory, then extend.
    task automatic ref_load(input bit w64, input logic [63:0] a, input logic [2:0] s,
                            output logic [63:0] d, output logic e, output bit cr);
        int xl = w64 ? 64 : 32;
        int nb = xl / 8;
        int sz;
        int off;
        case (s)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            3'd6:       sz = w64 ? 4 : 0;
            3'd3:       sz = w64 ? 8 : 0;
            default:    sz = 0;
        endcase
        d   = '0;
        e   = (sz == 0);
        off = int'(a % 64'(nb));
        cr  = !e && (off + sz > nb);
        if (TRAP && cr) e = 1'b1;
        if (!e) begin
            for (int i = 0; i < sz; i++)
                d |= {56'd0, byte_at(amask(w64, a + 64'(i)))} << (8 * i);
            if (!s[2] && sz * 8 < xl && d[sz*8-1])
                d |= ~((64'd1 << (sz * 8)) - 64'd1);
            if (!w64) d &= 64'h0000_0000_FFFF_FFFF;
        end
    endtask

    initial begin
        logic [63:0] ra, w;
        rd32 = '0;
        forever begin
            @(negedge clk);
            if (req32 === 1'b1) begin
                ra = {32'd0, ma32};
                q32.push_back(ra);
                repeat (lat) @(posedge clk);
                #1;
                w = rd_word(1'b0, ra);
                rd32 = w[31:0];
                resp32 = 1'b1;
                @(posedge clk);
                #1 resp32 = 1'b0;
            end
        end
    end

    initial begin
        logic [63:0] ra;
        rd64 = '0;
        forever begin
            @(negedge clk);
            if (req64 === 1'b1) begin
                ra = ma64;
                q64.push_back(ra);
                repeat (lat) @(posedge clk);
                #1;
                rd64 = rd_word(1'b1, ra);
                resp64 = 1'b1;
                @(posedge clk);
                #1 resp64 = 1'b0;
            end
        end
    end

    task automatic do_load(input bit w64, input logic [63:0] a, input logic [2:0] s,
                           input int l, output logic [63:0] got, output logic gerr);
        logic [63:0] d, al;
        logic        e;
        bit          cr;
        int          n;
        int          nreq;
        ref_load(w64, a, s, d, e, cr);
        al  = amask(w64, a & ~64'(w64 ? 7 : 3));
        lat = l;
        q32.delete();
        q64.delete();
        @(posedge clk);
        #1;
        if (w64) begin v64 = 1'b1; a64 = a; s64 = s; end
        else begin v32 = 1'b1; a32 = a[31:0]; s32 = s; end
        chk("ready_before", w64 ? rdy64 : rdy32, 1'b1);
        @(posedge clk);
        #1;
        v32 = 1'b0;
        v64 = 1'b0;
        n = 0;
        while ((w64 ? ov64 : ov32) !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        got  = w64 ? wd64 : {32'd0, wd32};
        gerr = w64 ? err64 : err32;
        chk("latency", 64'(n), e ? 64'd0 : (cr ? 64'(2 * l + 2) : 64'(l + 1)));
        chk("data", got, d);
        chk("err", gerr, e);
        nreq = w64 ? q64.size() : q32.size();
        chk("req_count", 64'(nreq), e ? 64'd0 : (cr ? 64'd2 : 64'd1));
        if (!e && nreq > 0) chk("req_addr0", w64 ? q64[0] : q32[0], al);
        if (!e && cr && nreq > 1)
            chk("req_addr1", w64 ? q64[1] : q32[1], amask(w64, al + 64'(w64 ? 8 : 4)));
        @(posedge clk);
        #1;
        chk("valid_pulse", w64 ? ov64 : ov32, 1'b0);
        chk("ready_after", w64 ? rdy64 : rdy32, 1'b1);
        chk("data_hold", w64 ? wd64 : {32'd0, wd32}, d);
    endtask

    initial begin
        logic [63:0] g;
        logic        ge;
        logic [63:0] ra;
        int          n;
        v32 = 1'b0; a32 = '0; s32 = '0;
        v64 = 1'b0; a64 = '0; s64 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", rdy32, 1'b1);
        chk("rst_req", req32, 1'b0);
        chk("rst_maddr", ma32, 64'd0);
        chk("rst_valid", ov32, 1'b0);
        chk("rst_data", wd32, 64'd0);
        chk("rst_err", err32, 1'b0);
        chk("rst_ready64", rdy64, 1'b1);
        chk("rst_data64", wd64, 64'd0);
        rst = 1'b0;

        put_word(64'h100, 64'h8000_00FF, 4);
        do_load(1'b0, 64'h100, 3'b010, 1, g, ge);
        chk("tp_lw", g, 64'h8000_00FF);
        put_word(64'h100, 64'h80AB_CDEF, 4);
        do_load(1'b0, 64'h103, 3'b000, 1, g, ge);
        chk("tp_lb", g, 64'hFFFF_FF80);
        do_load(1'b0, 64'h103, 3'b100, 2, g, ge);
        chk("tp_lbu", g, 64'h0000_0080);
        put_word(64'h200, 64'hAA00_0000, 4);
        put_word(64'h204, 64'h0000_00BB, 4);
        do_load(1'b0, 64'h203, 3'b001, 1, g, ge);
        chk("tp_lh_cross", g, TRAP ? 64'd0 : 64'hFFFF_BBAA);
        chk("tp_lh_cross_err", ge, TRAP);

        put_word(64'h1000, 64'h1111_2222_3333_4444, 8);
        put_word(64'h1008, 64'h5555_6666_7777_8888, 8);
        do_load(1'b1, 64'h1004, 3'b011, 1, g, ge);
        chk("tp_ld_cross", g, TRAP ? 64'd0 : 64'h7777_8888_1111_2222);
        put_word(64'h1000, 64'hF000_0000_0000_0000, 8);
        do_load(1'b1, 64'h1004, 3'b110, 1, g, ge);
        chk("tp_lwu64", g, 64'h0000_0000_F000_0000);
        do_load(1'b1, 64'h1004, 3'b010, 1, g, ge);
        chk("tp_lw64_sext", g, 64'hFFFF_FFFF_F000_0000);

        do_load(1'b0, 64'h300, 3'b011, 1, g, ge);
        chk("tp_illegal_err", ge, 1'b1);
        do_load(1'b0, 64'h300, 3'b110, 1, g, ge);
        do_load(1'b0, 64'h300, 3'b111, 1, g, ge);
        do_load(1'b1, 64'h300, 3'b111, 1, g, ge);
        do_load(1'b0, 64'h100, 3'b010, 1, g, ge);
        chk("tp_legal_after_err", ge, 1'b0);

        do_load(1'b0, 64'hFFFF_FFFE, 3'b010, 1, g, ge);
        do_load(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 2, g, ge);
        do_load(1'b1, 64'h2007, 3'b000, 3, g, ge);

        // Reset while the second beat of a crossing load is outstanding.
        lat = 6;
        q32.delete();
        @(posedge clk);
        #1;
        v32 = 1'b1; a32 = 32'h203; s32 = 3'b001;
        @(posedge clk);
        #1;
        v32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_load_no_valid", ov32, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_ready", rdy32, 1'b1);
        chk("mrst_req", req32, 1'b0);
        chk("mrst_maddr", ma32, 64'd0);
        chk("mrst_valid", ov32, 1'b0);
        chk("mrst_data", wd32, 64'd0);
        chk("mrst_err", err32, 1'b0);
        inj32 = 1'b1;
        @(posedge clk);
        #1;
        inj32 = 1'b0;
        n = 0;
        repeat (20) begin
            if (ov32 === 1'b1 || rdy32 !== 1'b1) n++;
            @(posedge clk);
            #1;
        end
        chk("stale_rvalid_ignored", 64'(n), 64'd0);
        put_word(64'h0, 64'h0000_007F, 4);
        do_load(1'b0, 64'h0, 3'b100, 1, g, ge);
        chk("post_reset_lbu", g, 64'h7F);

        for (int i = 0; i < 40; i++) begin
            ra = {32'd0, $urandom};
            if (i[0]) ra[63:32] = $urandom;
            do_load(i[0], amask(i[0], ra), 3'($urandom_range(0, 7)),
                    int'($urandom_range(1, 3)), g, ge);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/w_load_align_unit.md
Name: w_load_align_unit

Overview:
- Parametrised successor to the writeback load mux. Sits between the memory stage and the writeback stage and owns the data-memory read port for loads.
- Accepts a load request (address and funct3 load type) and issues one or two XLEN-wide aligned memory reads.
- Merges the read beats, shifts out the addressed bytes, then sign- or zero-extends them to XLEN and returns one writeback beat.
- Supports byte, half, word and (XLEN=64) double loads, signed and unsigned, including accesses that cross a memory-word boundary.

Parameters:
- XLEN, 32, datapath width in bits; legal values are 32 and 64.
- NB (localparam), XLEN/8, bytes per memory word.
- OFFW (localparam), $clog2(NB), width of the byte-offset field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_con_valid  in  1  load request valid.
- o_con_ready  out  1  unit can accept a request; high only in IDLE.
- i_data_addr  in  XLEN  byte address of the load.
- i_con_loadsig  in  3  funct3 load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- o_mem_req  out  1  single-cycle memory read request pulse.
- o_mem_addr  out  XLEN  word-aligned read address; low OFFW bits are always 0.
- i_mem_rvalid  in  1  read data valid.
- i_mem_rdata  in  XLEN  read data.
- o_con_valid  out  1  result valid, single-cycle pulse.
- o_data_Wdata  out  XLEN  extended load result.
- o_con_err  out  1  illegal loadsig flag; qualified by o_con_valid.

Behaviour:
- Reset (rst=1 at a clock edge): state returns to IDLE. o_con_ready=1 once in IDLE, o_mem_req=0, o_mem_addr=0, o_con_valid=0, o_data_Wdata=0, o_con_err=0.
- Reset mid-operation abandons the in-flight load. Any i_mem_rvalid arriving after reset, while in IDLE, is ignored.
- Size in bytes: 1 for LB/LBU, 2 for LH/LHU, 4 for LW/LWU, 8 for LD.
- Illegal codes: 111 always; 011 and 110 when XLEN=32. An illegal code gives size 0, no memory read, and a result of 0 with o_con_err=1.
- Signed codes (LB, LH, LW) replicate the top selected bit. Unsigned codes zero-fill. LD and LW at XLEN=32 return the data unextended.
- Offset = addr[OFFW-1:0]. Cross = (offset + size > NB).
- States: IDLE, RD0, WT0, RD1, WT1, RESP.
- IDLE: on i_con_valid & o_con_ready, latch addr, loadsig, offset and cross.
  - Legal code: go to RD0.
  - Illegal code: go directly to RESP.
- RD0: o_mem_req=1 for one cycle, o_mem_addr = addr with low OFFW bits cleared. Go to WT0.
- WT0: wait for i_mem_rvalid and capture rdata into beat0.
  - cross=1: go to RD1.
  - cross=0: go to RESP.
- RD1: o_mem_req=1, o_mem_addr = aligned addr + NB, wrapping modulo 2^XLEN. Go to WT1.
- WT1: on i_mem_rvalid capture beat1. Go to RESP.
- RESP: register the result.
  - Result = low size bytes of ({beat1, beat0} >> (offset*8)), then extended. beat1 is treated as 0 when cross=0.
  - o_con_valid=1 for exactly this cycle. Next state is IDLE.
- o_data_Wdata and o_con_err hold their values until the next RESP.
- i_mem_rvalid in RD0, RD1, RESP or IDLE is ignored. At most one read is outstanding. Memory latency is unbounded, minimum 1 cycle after the request.
- Minimum latency, accept to o_con_valid: aligned load 4 cycles (accept, RD0, WT0 with rvalid, RESP); crossing load 6 cycles. o_con_ready returns high the cycle after RESP.
- i_con_valid while o_con_ready=0 is not accepted; the upstream stage must hold its request.

Optional Feature:
- Macro MISALIGN_TRAP_EN. When defined, a crossing access performs no memory read. It goes IDLE -> RESP with o_data_Wdata=0 and o_con_err=1, so RD1 and WT1 are unreachable. Naturally aligned loads are unaffected.
- When undefined, crossing accesses are split into two reads as described above, and o_con_err flags only illegal loadsig.

Test Plan:
- XLEN=32, LW at addr 0x100, rdata 0x8000_00FF with 1-cycle latency: one req with addr 0x100; o_data_Wdata=0x8000_00FF and o_con_valid arrive 4 cycles after accept; err=0.
- LB at addr 0x103, rdata 0x80AB_CDEF: result 0xFFFF_FF80. Same access as LBU: result 0x0000_0080.
- LH at addr 0x203, beat0 0xAA00_0000 from 0x200, beat1 0x0000_00BB from 0x204: two reqs, addresses 0x200 then 0x204; result 0xFFFF_BBAA. With MISALIGN_TRAP_EN defined: no req issued, result 0, err=1.
- XLEN=64, LD at addr 0x1004, beat0 0x1111_2222_3333_4444, beat1 0x5555_6666_7777_8888: result 0x7777_8888_1111_2222. LWU at 0x1004, aligned, beat0 0xF000_0000_0000_0000: result 0x0000_0000_F000_0000.
- XLEN=32, loadsig 011: no req, o_con_valid 2 cycles after accept, result 0, err=1. Then issue a legal LW and check err=0.
- Reset asserted in WT1 of a crossing load, with a stale rvalid injected in the first IDLE cycle: all outputs are 0 and ready=1; the stale rvalid produces no o_con_valid. A following LBU at 0x0 with rdata 0x7F returns 0x7F.
